rv32imf_instr_mem_responder: RTL and testbench
==============================================

Name: rv32imf_instr_mem_responder

Overview:
- OBI-style instruction-memory responder: the memory end of the instruction fetch bus that the prefetch controller drives.
- Accepts word fetch requests through a req/gnt handshake and holds a word-addressed instruction store.
- Returns in-order rdata/err responses at a fixed latency, with a configurable cap on outstanding transactions and optional pseudo-random grant stalls.
- Used as the instruction-side memory in core-level benches and FPGA builds; responses carry no ready, so the consumer is always ready.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words in the store (power of two, >=4).
- BASE_ADDR, 32'h0000_0000, byte address of word 0 (word aligned).
- LATENCY, 2, cycles from accept to rvalid (>=1).
- MAX_OUTSTANDING, 4, maximum accepted-but-unanswered transactions (1..8).
- LFSR_SEED, 8'hA5, reset value of the stall LFSR (nonzero).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- instr_req_i  input  1  fetch request valid.
- instr_addr_i  input  32  fetch byte address; bits [1:0] ignored.
- instr_gnt_o  output  1  request accepted this cycle (combinational).
- instr_rvalid_o  output  1  response valid (registered).
- instr_rdata_o  output  32  response word; 0 when rvalid=0 or err=1.
- instr_err_o  output  1  out-of-range access; valid with rvalid.
- stall_en_i  input  1  enable pseudo-random grant stalls.
- load_we_i  input  1  backdoor word write.
- load_addr_i  input  $clog2(MEM_WORDS)  backdoor word index.
- load_wdata_i  input  32  backdoor write data.
- outstanding_o  output  4  current outstanding count (cnt_q).

Behaviour:
- Reset (rst=1 at a clock edge): cnt_q=0, all pipeline stages invalid, lfsr_q=LFSR_SEED. Outputs in the following cycle: rvalid=0, rdata=0, err=0, outstanding_o=0. Memory contents are not reset.
- Reset mid-operation: in-flight responses are discarded and never issued. gnt is forced to 0 while rst=1.
- Accept: accept = instr_req_i && instr_gnt_o.
  - instr_gnt_o = instr_req_i && !rst && (cnt_q < MAX_OUTSTANDING) && !(stall_en_i && lfsr_q[0]).
  - Uses registered cnt_q only, so a response in the same cycle does not free a slot until the next cycle.
- Address decode at accept:
  - idx = (addr - BASE_ADDR) >> 2.
  - in_range = (addr >= BASE_ADDR) && (idx < MEM_WORDS); 32-bit unsigned compare, no wrap.
- Data capture: data is read from the array in the accept cycle and carried in the pipeline; later writes do not affect it.
  - A backdoor write to the same index in the accept cycle: the old data is returned; the write takes effect at that edge.
  - Out-of-range: captured data = 0, err = 1.
- Pipeline: a LATENCY-stage shift register of {valid, err, data}, shifted every cycle.
  - Stage 0 is loaded with accept.
  - rvalid/err/rdata are driven from the last stage register.
  - Accept at cycle t gives rvalid in cycle t+LATENCY. Responses are strictly in order; back-to-back accepts give back-to-back rvalids.
- Counter: cnt_next = cnt_q + accept - rvalid (both in the same cycle means no change). It never exceeds MAX_OUTSTANDING and never underflows.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4, shifts left. It advances every cycle when stall_en_i=1 and holds otherwise. A stall is applied whenever lfsr_q[0]=1 and stall_en_i=1.
- Request rules: the requester may change or drop the address while gnt=0; no stability is required. The responder never stores an ungranted request.
- Backdoor write: mem[load_addr_i] <= load_wdata_i whenever load_we_i=1, regardless of bus activity.

Test Plan:
- LATENCY=2, stall off: load words 0..3 = 11,22,33,44, then req held 4 cycles at addr 0,4,8,C from t0 -> gnt=1 at t0..t3; rvalid t2..t5 with rdata 11,22,33,44; err=0; outstanding peaks at 2.
- LATENCY=4, MAX_OUTSTANDING=2, req held high from t0 -> gnt at t0,t1; gnt=0 t2..t4; rvalid at t4,t5; gnt again at t5.
- Out of range, MEM_WORDS=1024, addr 0x1000 -> rvalid after LATENCY with err=1, rdata=0. Addr 0x6 -> returns word 1, err=0.
- Collision: accept addr 0x8 while load_we writes idx 2 = 0xDEAD -> response returns old data; a re-fetch of 0x8 returns 0xDEAD.
- Reset mid-flight: 2 accepted, rst=1 one cycle -> no rvalid ever issued for them; outstanding_o=0; next request granted and answered after LATENCY.
- stall_en_i=1 with req held high -> gnt pattern matches a reference LFSR from seed A5 (gnt=0 exactly when lfsr_q[0]=1); all granted responses arrive in order.

Source files
------------

// File: rtl/rv32imf_instr_mem_responder_if.sv
// Instruction fetch bus between the prefetch controller (master) and the
// instruction memory (slave): req/gnt request channel plus rvalid/rdata/err response.
interface rv32imf_instr_mem_responder_if;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_gnt;
  logic        instr_rvalid;
  logic [31:0] instr_rdata;
  logic        instr_err;

  modport master (
    output instr_req,
    output instr_addr,
    input  instr_gnt,
    input  instr_rvalid,
    input  instr_rdata,
    input  instr_err
  );

  modport slave (
    input  instr_req,
    input  instr_addr,
    output instr_gnt,
    output instr_rvalid,
    output instr_rdata,
    output instr_err
  );
endinterface

// File: rtl/rv32imf_instr_mem_responder.sv
// Instruction-memory responder: word store with backdoor load, fixed-latency
// in-order responses, outstanding-transaction cap and optional LFSR grant stalls.
module rv32imf_instr_mem_responder #(
  parameter int          MEM_WORDS       = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int          LATENCY         = 2,
  parameter int          MAX_OUTSTANDING = 4,
  parameter logic [7:0]  LFSR_SEED       = 8'hA5
) (
  input  logic                         clk,
  input  logic                         rst,
  rv32imf_instr_mem_responder_if.slave bus,
  input  logic                         stall_en_i,
  input  logic                         load_we_i,
  input  logic [$clog2(MEM_WORDS)-1:0] load_addr_i,
  input  logic [31:0]                  load_wdata_i,
  output logic [3:0]                   outstanding_o
);

  localparam int          AW          = $clog2(MEM_WORDS);
  localparam logic [3:0]  MAX_CNT     = 4'(MAX_OUTSTANDING);
  localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

  logic [31:0] mem [MEM_WORDS];

  logic [3:0]                cnt_q, cnt_d;
  logic [7:0]                lfsr_q, lfsr_d;
  logic [LATENCY-1:0]        vld_q, vld_d;
  logic [LATENCY-1:0]        err_q, err_d;
  logic [LATENCY-1:0][31:0]  data_q, data_d;

  logic        gnt_s;
  logic        accept_s;
  logic        rsp_fire_s;
  logic [31:0] offset_s;
  logic        in_range_s;
  logic [AW-1:0] idx_s;
  logic [31:0] rd_word_s;
  logic        lfsr_fb_s;
  logic        unused_offset_s;

  // Address decode and asynchronous array read for the request in flight.
  always_comb begin
    offset_s        = bus.instr_addr - BASE_ADDR;
    // Both halves of the range check are needed: the subtraction can wrap.
    in_range_s      = (bus.instr_addr >= BASE_ADDR) &&
                      ({2'b00, offset_s[31:2]} < MEM_WORDS_W);
    idx_s           = offset_s[AW+1:2];
    rd_word_s       = mem[idx_s];
    unused_offset_s = ^offset_s[1:0];
  end

  // Grant only from registered state so a same-cycle response never frees a slot.
  always_comb begin
    gnt_s      = bus.instr_req && !rst && (cnt_q < MAX_CNT) &&
                 !(stall_en_i && lfsr_q[0]);
    accept_s   = bus.instr_req && gnt_s;
    rsp_fire_s = vld_q[LATENCY-1];
  end

  // Outstanding counter and stall LFSR next state.
  always_comb begin
    cnt_d     = cnt_q;
    lfsr_d    = lfsr_q;
    lfsr_fb_s = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    case ({accept_s, rsp_fire_s})
      2'b10:   cnt_d = cnt_q + 4'd1;
      2'b01:   cnt_d = cnt_q - 4'd1;
      default: cnt_d = cnt_q;
    endcase
    if (stall_en_i) begin
      lfsr_d = {lfsr_q[6:0], lfsr_fb_s};
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // Response pipeline: stage 0 captures the accepted word, later stages shift.
  always_comb begin
    vld_d  = '0;
    err_d  = '0;
    data_d = '0;
    vld_d[0] = accept_s;
    err_d[0] = accept_s && !in_range_s;
    if (accept_s && in_range_s) begin
      data_d[0] = rd_word_s;
    end else begin
      data_d[0] = 32'h0000_0000;
    end
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i]  = vld_q[i-1];
      err_d[i]  = err_q[i-1];
      data_d[i] = data_q[i-1];
    end
  end

  // Control and pipeline state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 4'd0;
      lfsr_q <= LFSR_SEED;
      vld_q  <= '0;
      err_q  <= '0;
      data_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      lfsr_q <= lfsr_d;
      vld_q  <= vld_d;
      err_q  <= err_d;
      data_q <= data_d;
    end
  end

  // Backdoor load port; contents survive reset.
  always_ff @(posedge clk) begin
    if (load_we_i) begin
      mem[load_addr_i] <= load_wdata_i;
    end
  end

  assign bus.instr_gnt    = gnt_s;
  assign bus.instr_rvalid = vld_q[LATENCY-1];
  assign bus.instr_err    = err_q[LATENCY-1];
  assign bus.instr_rdata  = data_q[LATENCY-1];
  assign outstanding_o    = cnt_q;

endmodule

// File: tb/tb_rv32imf_instr_mem_responder.sv
// Directed bench: vector table on a LATENCY=2 instance, hand sequences on a
// LATENCY=4/MAX_OUTSTANDING=2 instance, and an LFSR-stall run against a reference model.
module tb_rv32imf_instr_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  rv32imf_instr_mem_responder_if bus_a ();
  rv32imf_instr_mem_responder_if bus_b ();

  logic        rst_a, rst_b;
  logic        stall_a, stall_b;
  logic        we_a, we_b;
  logic [9:0]  la_a, la_b;
  logic [31:0] wd_a, wd_b;
  logic [3:0]  cnt_a, cnt_b;

  rv32imf_instr_mem_responder u_a (
    .clk(clk), .rst(rst_a), .bus(bus_a.slave), .stall_en_i(stall_a),
    .load_we_i(we_a), .load_addr_i(la_a), .load_wdata_i(wd_a), .outstanding_o(cnt_a)
  );

  rv32imf_instr_mem_responder #(.LATENCY(4), .MAX_OUTSTANDING(2)) u_b (
    .clk(clk), .rst(rst_b), .bus(bus_b.slave), .stall_en_i(stall_b),
    .load_we_i(we_b), .load_addr_i(la_b), .load_wdata_i(wd_b), .outstanding_o(cnt_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [9:0]  la;
    logic [31:0] wd;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mv(input logic rst, input logic req, input logic [31:0] addr,
                              input logic we, input logic [9:0] la, input logic [31:0] wd,
                              input logic gnt, input logic rv, input logic [31:0] rdata,
                              input logic err, input logic [3:0] cnt);
    vec_t v;
    v.rst = rst; v.req = req; v.addr = addr; v.we = we; v.la = la; v.wd = wd;
    v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.err = err; v.cnt = cnt;
    return v;
  endfunction

  logic [5:0]  gnt_pat_b = 6'b100011;
  logic [5:0]  rv_pat_b  = 6'b110000;
  logic [31:0] words_a [4];
  logic [7:0]  ref_lfsr;
  logic [63:0] exp_rv;
  logic [31:0] exp_data [64];
  int          cnt_m;
  logic        exp_g;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; stall_a = 1'b0; stall_b = 1'b0;
    we_a = 1'b0; we_b = 1'b0; la_a = 10'd0; la_b = 10'd0; wd_a = 32'h0; wd_b = 32'h0;
    bus_a.instr_req = 1'b0; bus_a.instr_addr = 32'h0;
    bus_b.instr_req = 1'b0; bus_b.instr_addr = 32'h0;

    //        rst   req   addr           we    la        wd              gnt   rv    rdata          err   cnt
    vecs.push_back(mv(1'b0, 1'b0, 32'h0000_0000, 1'b1, 10'd0,    32'h0000_0011, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 4'd0));
    vecs.push_back(mv(1'b0, 1'b0, 32'h0000_0000, 1'b1, 10'd1,    32'h0000_0022, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 4'd0));
    vecs.push_back(mv(1'b0, 1'b0, 32'h0000_0000, 1'b1, 10'd2,    32'h0000_0033, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 4'd0));
    vecs.push_back(mv(1'b0, 1'b0, 32'h0000_0000, 1'b1, 10'd3,    32'h0000_0044, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 4'd0));
    vecs.push_back(mv(1'b0, 1'b1, 32'h0000_0000, 1'b0, 10'd0,    32'h0,         1'b1, 1'b0, 32'h0000_0000, 1'b0, 4'd0));
    vecs.push_back(mv(1'b0, 1'b1, 32'h0000_0004, 1'b0, 10'd0,    32'h0,         1'b1, 1'b0, 32'h0000_0000, 1'b0, 4'd1));
    vecs.push_back(mv(1'b0, 1'b1, 32'h0000_0008, 1'b0, 10'd0,    32'h0,         1'b1, 1'b1, 32'h0000_0011, 1'b0, 4'd2));
    vecs.push_back(mv(1'b0, 1'b1, 32'h0000_000C, 1'b0, 10'd0,    32'h0,         1'b1, 1'b1, 32'h0000_0022, 1'b0, 4'd2));
    vecs.push_back(mv(1'b0, 1'b0, 32'h0000_0000, 1'b0, 10'd0,    32'h0,         1'b0, 1'b1, 32'h0000_0033, 1'b0, 4'd2));
    vecs.push_back(mv(1'b0, 1'b0, 32'h0000_0000, 1'b0, 10'd0,    32'h0,         1'b0, 1'b1, 32'h0000_0044, 1'b0, 4'd1));
    vecs.push_back(mv(1'b0, 1'b0, 32'h0000_0000, 1'b0, 10'd0,    32'h0,         1'b0, 1'b0, 32'h0000_0000, 1'b0, 4'd0));
    vecs.push_back(mv(1'b0, 1'b1, 32'h0000_1000, 1'b0, 10'd0,    32'h0,         1'b1, 1'b0, 32'h0000_0000, 1'b0, 4'd0));
    vecs.push_back(mv(1'b0, 1'b1, 32'h0000_0006, 1'b0, 10'd0,    32'h0,         1'b1, 1'b0, 32'h0000_0000, 1'b0, 4'd1));
    vecs.push_back(mv(1'b0, 1'b0, 32'h0000_0000, 1'b0, 10'd0,    32'h0,         1'b0, 1'b1, 32'h0000_0000, 1'b1, 4'd2));
    vecs.push_back(mv(1'b0, 1'b0, 32'h0000_0000, 1'b0, 10'd0,    32'h0,         1'b0, 1'b1, 32'h0000_0022, 1'b0, 4'd1));
    vecs.push_back(mv(1'b0, 1'b0, 32'h0000_0000, 1'b0, 10'd0,    32'h0,         1'b0, 1'b0, 32'h0000_0000, 1'b0, 4'd0));
    vecs.push_back(mv(1'b0, 1'b0, 32'h0000_0000, 1'b1, 10'd1023, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 4'd0));
    vecs.push_back(mv(1'b0, 1'b1, 32'h0000_0FFC, 1'b0, 10'd0,    32'h0,         1'b1, 1'b0, 32'h0000_0000, 1'b0, 4'd0));
    vecs.push_back(mv(1'b0, 1'b0, 32'h0000_0000, 1'b0, 10'd0,    32'h0,         1'b0, 1'b0, 32'h0000_0000, 1'b0, 4'd1));
    vecs.push_back(mv(1'b0, 1'b0, 32'h0000_0000, 1'b0, 10'd0,    32'h0,         1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, 4'd1));
    vecs.push_back(mv(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 10'd0,    32'h0,         1'b1, 1'b0, 32'h0000_0000, 1'b0, 4'd0));
    vecs.push_back(mv(1'b0, 1'b0, 32'h0000_0000, 1'b0, 10'd0,    32'h0,         1'b0, 1'b0, 32'h0000_0000, 1'b0, 4'd1));
    vecs.push_back(mv(1'b0, 1'b0, 32'h0000_0000, 1'b0, 10'd0,    32'h0,         1'b0, 1'b1, 32'h0000_0000, 1'b1, 4'd1));
    vecs.push_back(mv(1'b0, 1'b0, 32'h0000_0000, 1'b0, 10'd0,    32'h0,         1'b0, 1'b0, 32'h0000_0000, 1'b0, 4'd0));
    vecs.push_back(mv(1'b0, 1'b1, 32'h0000_0008, 1'b1, 10'd2,    32'h0000_DEAD, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 4'd0));
    vecs.push_back(mv(1'b0, 1'b1, 32'h0000_0008, 1'b0, 10'd0,    32'h0,         1'b1, 1'b0, 32'h0000_0000, 1'b0, 4'd1));
    vecs.push_back(mv(1'b0, 1'b0, 32'h0000_0000, 1'b0, 10'd0,    32'h0,         1'b0, 1'b1, 32'h0000_0033, 1'b0, 4'd2));
    vecs.push_back(mv(1'b0, 1'b0, 32'h0000_0000, 1'b0, 10'd0,    32'h0,         1'b0, 1'b1, 32'h0000_DEAD, 1'b0, 4'd1));
    vecs.push_back(mv(1'b0, 1'b0, 32'h0000_0000, 1'b0, 10'd0,    32'h0,         1'b0, 1'b0, 32'h0000_0000, 1'b0, 4'd0));
    vecs.push_back(mv(1'b0, 1'b1, 32'h0000_0000, 1'b0, 10'd0,    32'h0,         1'b1, 1'b0, 32'h0000_0000, 1'b0, 4'd0));
    vecs.push_back(mv(1'b1, 1'b1, 32'h0000_0004, 1'b0, 10'd0,    32'h0,         1'b0, 1'b0, 32'h0000_0000, 1'b0, 4'd1));
    vecs.push_back(mv(1'b0, 1'b0, 32'h0000_0000, 1'b0, 10'd0,    32'h0,         1'b0, 1'b0, 32'h0000_0000, 1'b0, 4'd0));
    vecs.push_back(mv(1'b0, 1'b0, 32'h0000_0000, 1'b0, 10'd0,    32'h0,         1'b0, 1'b0, 32'h0000_0000, 1'b0, 4'd0));
    vecs.push_back(mv(1'b0, 1'b1, 32'h0000_0004, 1'b0, 10'd0,    32'h0,         1'b1, 1'b0, 32'h0000_0000, 1'b0, 4'd0));
    vecs.push_back(mv(1'b0, 1'b0, 32'h0000_0000, 1'b0, 10'd0,    32'h0,         1'b0, 1'b0, 32'h0000_0000, 1'b0, 4'd1));
    vecs.push_back(mv(1'b0, 1'b0, 32'h0000_0000, 1'b0, 10'd0,    32'h0,         1'b0, 1'b1, 32'h0000_0022, 1'b0, 4'd1));
    vecs.push_back(mv(1'b0, 1'b0, 32'h0000_0000, 1'b0, 10'd0,    32'h0,         1'b0, 1'b0, 32'h0000_0000, 1'b0, 4'd0));

    repeat (2) @(posedge clk);

    // Table on instance A (LATENCY=2, MAX_OUTSTANDING=4); row 0 shows the reset state.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_a = vecs[i].rst; rst_b = 1'b0;
      bus_a.instr_req = vecs[i].req; bus_a.instr_addr = vecs[i].addr;
      we_a = vecs[i].we; la_a = vecs[i].la; wd_a = vecs[i].wd;
      #2;
      chk("a_gnt",    i, 32'(bus_a.instr_gnt),    32'(vecs[i].gnt));
      chk("a_rvalid", i, 32'(bus_a.instr_rvalid), 32'(vecs[i].rv));
      chk("a_rdata",  i, bus_a.instr_rdata,       vecs[i].rdata);
      chk("a_err",    i, 32'(bus_a.instr_err),    32'(vecs[i].err));
      chk("a_cnt",    i, 32'(cnt_a),              32'(vecs[i].cnt));
    end
    @(negedge clk);
    rst_a = 1'b0; bus_a.instr_req = 1'b0; we_a = 1'b0;

    // Instance B: load words 0..3.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      we_b = 1'b1; la_b = 10'(i); wd_b = 32'(8'h11 * (i + 1));
    end
    @(negedge clk);
    we_b = 1'b0;

    // Instance B: cap of 2 outstanding with LATENCY=4 and req held high.
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      bus_b.instr_req = 1'b1; bus_b.instr_addr = 32'h0000_0000;
      #2;
      chk("b_cap_gnt",    t, 32'(bus_b.instr_gnt),    32'(gnt_pat_b[t]));
      chk("b_cap_rvalid", t, 32'(bus_b.instr_rvalid), 32'(rv_pat_b[t]));
      chk("b_cap_rdata",  t, bus_b.instr_rdata,       rv_pat_b[t] ? 32'h0000_0011 : 32'h0);
    end
    @(negedge clk);
    bus_b.instr_req = 1'b0;
    repeat (6) @(negedge clk);
    #2;
    chk("b_drain_cnt", 0, 32'(cnt_b), 32'd0);

    // Instance B: reset with two transactions in flight.
    @(negedge clk);
    bus_b.instr_req = 1'b1; bus_b.instr_addr = 32'h0000_0004;
    #2 chk("b_rst_gnt0", 0, 32'(bus_b.instr_gnt), 32'd1);
    @(negedge clk);
    bus_b.instr_addr = 32'h0000_0008;
    #2 chk("b_rst_gnt1", 1, 32'(bus_b.instr_gnt), 32'd1);
    @(negedge clk);
    rst_b = 1'b1; bus_b.instr_addr = 32'h0000_000C;
    #2;
    chk("b_rst_gnt_forced", 2, 32'(bus_b.instr_gnt), 32'd0);
    chk("b_rst_cnt_before", 2, 32'(cnt_b), 32'd2);
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      rst_b = 1'b0; bus_b.instr_req = 1'b0;
      #2;
      chk("b_rst_no_rvalid", t, 32'(bus_b.instr_rvalid), 32'd0);
      chk("b_rst_cnt",       t, 32'(cnt_b),              32'd0);
    end
    @(negedge clk);
    bus_b.instr_req = 1'b1; bus_b.instr_addr = 32'h0000_000C;
    #2 chk("b_post_gnt", 0, 32'(bus_b.instr_gnt), 32'd1);
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      bus_b.instr_req = 1'b0;
      #2;
      chk("b_post_rvalid", t, 32'(bus_b.instr_rvalid), (t == 4) ? 32'd1 : 32'd0);
      chk("b_post_rdata",  t, bus_b.instr_rdata,       (t == 4) ? 32'h0000_0044 : 32'h0);
    end

    // Instance A: pseudo-random stalls against a reference LFSR from the seed.
    words_a[0] = 32'h0000_0011; words_a[1] = 32'h0000_0022;
    words_a[2] = 32'h0000_DEAD; words_a[3] = 32'h0000_0044;
    @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    ref_lfsr = 8'hA5;
    exp_rv = 64'd0;
    cnt_m = 0;
    for (int i = 0; i < 64; i++) exp_data[i] = 32'h0;
    for (int i = 0; i < 44; i++) begin
      @(negedge clk);
      stall_a = (i < 40);
      bus_a.instr_req = (i < 40);
      bus_a.instr_addr = 32'((i % 4) * 4);
      #2;
      exp_g = (i < 40) && !ref_lfsr[0] && (cnt_m < 4);
      chk("stall_gnt",    i, 32'(bus_a.instr_gnt),    32'(exp_g));
      chk("stall_rvalid", i, 32'(bus_a.instr_rvalid), 32'(exp_rv[i]));
      chk("stall_rdata",  i, bus_a.instr_rdata,       exp_data[i]);
      chk("stall_cnt",    i, 32'(cnt_a),              32'(cnt_m));
      if (exp_g) begin
        exp_rv[i+2] = 1'b1;
        exp_data[i+2] = words_a[i % 4];
      end
      cnt_m = cnt_m + (exp_g ? 1 : 0) - (exp_rv[i] ? 1 : 0);
      if (i < 40) ref_lfsr = {ref_lfsr[6:0], ref_lfsr[7] ^ ref_lfsr[5] ^ ref_lfsr[4] ^ ref_lfsr[3]};
    end
    @(negedge clk);
    stall_a = 1'b0; bus_a.instr_req = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
